// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, typedefs and constants for the register file slice
package reg_file_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the register file
// master: drives read addresses, issue and writeback; slave: returns data, hazard status, dbg_reg, sb_err
interface reg_file_sb_if import reg_file_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0] rd_busy;
  logic stall;
  logic iss_valid;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] dbg_reg;
  logic sb_err;
  modport master (
    output rd_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
    input rd_data, rd_busy, stall, dbg_reg, sb_err
  );
  modport slave (
    input rd_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
    output rd_data, rd_busy, stall, dbg_reg, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits, issue/writeback priority, sticky protocol error, per-port busy lookup
// in: clk, rst_n, iss_valid/iss_addr, wb_valid/wb_addr, packed rd_addr; out: busy_rd per port, sb_err
module reg_scoreboard import reg_file_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0] busy_rd,
  output logic sb_err
);
  logic [2**ADDR_WIDTH-1:0] busy;
  logic iss_en, wb_en, err_now;
  assign iss_en = iss_valid && iss_addr != ADDR_WIDTH'(REG_ZERO);
  assign wb_en = wb_valid && wb_addr != ADDR_WIDTH'(REG_ZERO);
  assign err_now = (iss_en && busy[iss_addr] && !(wb_en && wb_addr == iss_addr)) || (wb_en && !busy[wb_addr]);
  // set is applied after clear so a same-cycle new producer keeps the bit set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      sb_err <= 1'b0;
    end else begin
      if (wb_en) busy[wb_addr] <= 1'b0;
      if (iss_en) busy[iss_addr] <= 1'b1;
      if (err_now) sb_err <= 1'b1;
    end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_lk
    assign busy_rd[g] = busy[rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]];
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with combinational reads, scoreboard and registered debug tap
// ports: clk, rst_n (async active-low), bus (reg_file_sb_if.slave); optional forwarding via REGFILE_BYPASS_EN
module reg_file_sb import reg_file_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD = 2,
  parameter int DBG_REG = 10
) (
  input logic clk,
  input logic rst_n,
  reg_file_sb_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [NUM_RD-1:0] sb_busy;
  logic wb_en;
  assign wb_en = bus.wb_valid && bus.wb_addr != ADDR_WIDTH'(REG_ZERO);
  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)) u_sb (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(bus.iss_valid), .iss_addr(bus.iss_addr),
    .wb_valid(bus.wb_valid), .wb_addr(bus.wb_addr),
    .rd_addr(bus.rd_addr), .busy_rd(sb_busy), .sb_err(bus.sb_err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
      bus.dbg_reg <= '0;
    end else begin
      if (wb_en) mem[bus.wb_addr] <= bus.wb_data;
      bus.dbg_reg <= mem[DBG_REG];
    end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = bus.rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wb_en && bus.wb_addr == a;
    assign bus.rd_data[g*DATA_WIDTH +: DATA_WIDTH] = hit ? bus.wb_data : mem[a];
    // a same-cycle reissue to the forwarded register keeps the port busy
    assign bus.rd_busy[g] = sb_busy[g] && !(hit && !(bus.iss_valid && bus.iss_addr == a));
`else
    assign bus.rd_data[g*DATA_WIDTH +: DATA_WIDTH] = mem[a];
    assign bus.rd_busy[g] = sb_busy[g];
`endif
  end
  assign bus.stall = |bus.rd_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb
module tb_reg_file_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  reg_file_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) bus ();
  reg_file_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .DBG_REG(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    bus.rd_addr[p*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rdat(input int p);
    return bus.rd_data[p*32 +: 32];
  endfunction

  task automatic idle;
    bus.iss_valid = 1'b0;
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_reset;
    int nz = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(31 - a));
      #1;
      if (rdat(0) !== 32'd0 || rdat(1) !== 32'd0 || bus.stall !== 1'b0) nz++;
    end
    total++;
    if (nz !== 0) begin bad++; $display("FAIL reset_reads got=%0d nonzero exp=0", nz); end
    total++;
    if (bus.dbg_reg !== 32'd0) begin bad++; $display("FAIL reset_dbg got=%h exp=0", bus.dbg_reg); end
    total++;
    if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.sb_err); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
    tick;
    bus.iss_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    set_rd(0, 5'd5);
    #1;
    total++;
    if (rdat(0) !== (BYP ? 32'hDEADBEEF : 32'd0)) begin bad++; $display("FAIL wr_same_cycle got=%h exp=%h", rdat(0), BYP ? 32'hDEADBEEF : 32'd0); end
    total++;
    if (bus.rd_busy[0] !== !BYP) begin bad++; $display("FAIL wr_same_busy got=%b exp=%b", bus.rd_busy[0], !BYP); end
    tick;
    idle;
    #1;
    total++;
    if (rdat(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_next_cycle got=%h exp=deadbeef", rdat(0)); end
    total++;
    if (bus.rd_busy[0] !== 1'b0 || bus.sb_err !== 1'b0) begin bad++; $display("FAIL wr_next_status got=%b%b exp=00", bus.rd_busy[0], bus.sb_err); end
  endtask

  task automatic test_busy;
    set_rd(0, 5'd7); set_rd(1, 5'd0);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    #1;
    total++;
    if (bus.stall !== 1'b0) begin bad++; $display("FAIL busy_pre_edge got=%b exp=0", bus.stall); end
    tick;
    bus.iss_valid = 1'b0;
    #1;
    total++;
    if (bus.rd_busy !== 2'b01 || bus.stall !== 1'b1) begin bad++; $display("FAIL busy_set got=%b/%b exp=01/1", bus.rd_busy, bus.stall); end
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h12;
    #1;
    total++;
    if (bus.stall !== !BYP) begin bad++; $display("FAIL busy_wb_cycle got=%b exp=%b", bus.stall, !BYP); end
    tick;
    idle;
    #1;
    total++;
    if (rdat(0) !== 32'h12 || bus.stall !== 1'b0 || bus.sb_err !== 1'b0) begin bad++; $display("FAIL busy_clear got=%h/%b/%b exp=12/0/0", rdat(0), bus.stall, bus.sb_err); end
  endtask

  task automatic test_zero;
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
    #1;
    total++;
    if (rdat(0) !== 32'd0 || bus.stall !== 1'b0) begin bad++; $display("FAIL zero_same got=%h/%b exp=0/0", rdat(0), bus.stall); end
    tick;
    idle;
    #1;
    total++;
    if (rdat(0) !== 32'd0 || rdat(1) !== 32'd0 || bus.rd_busy !== 2'b00) begin bad++; $display("FAIL zero_after got=%h/%b exp=0/00", rdat(0), bus.rd_busy); end
    total++;
    if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp=0", bus.sb_err); end
  endtask

  task automatic test_same_cycle;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
    tick;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    set_rd(1, 5'd3);
    #1;
    total++;
    if (bus.rd_busy[1] !== 1'b1) begin bad++; $display("FAIL same_busy_cycle got=%b exp=1", bus.rd_busy[1]); end
    tick;
    idle;
    #1;
    total++;
    if (bus.rd_busy[1] !== 1'b1 || rdat(1) !== 32'h33 || bus.sb_err !== 1'b0) begin bad++; $display("FAIL same_after got=%b/%h/%b exp=1/33/0", bus.rd_busy[1], rdat(1), bus.sb_err); end
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h34;
    tick;
    idle;
    #1;
    total++;
    if (bus.rd_busy[1] !== 1'b0 || rdat(1) !== 32'h34 || bus.sb_err !== 1'b0) begin bad++; $display("FAIL same_drain got=%b/%h/%b exp=0/34/0", bus.rd_busy[1], rdat(1), bus.sb_err); end
    set_rd(0, 5'd9);
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    #1;
    total++;
    if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL err_pre_edge got=%b exp=0", bus.sb_err); end
    tick;
    idle;
    #1;
    total++;
    if (bus.sb_err !== 1'b1 || rdat(0) !== 32'h99) begin bad++; $display("FAIL err_set got=%b/%h exp=1/99", bus.sb_err, rdat(0)); end
    tick;
    tick;
    total++;
    if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.sb_err); end
  endtask

  task automatic test_dbg_and_reset;
    set_rd(0, 5'd10);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd10;
    tick;
    bus.iss_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h55;
    tick;
    idle;
    #1;
    total++;
    if (bus.dbg_reg !== 32'd0 || rdat(0) !== 32'h55) begin bad++; $display("FAIL dbg_lag got=%h/%h exp=0/55", bus.dbg_reg, rdat(0)); end
    tick;
    total++;
    if (bus.dbg_reg !== 32'h55) begin bad++; $display("FAIL dbg_update got=%h exp=55", bus.dbg_reg); end
    set_rd(1, 5'd12);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd12;
    tick;
    bus.iss_valid = 1'b0;
    #1;
    total++;
    if (bus.rd_busy !== 2'b10) begin bad++; $display("FAIL pre_reset_busy got=%b exp=10", bus.rd_busy); end
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h77;
    rst_n = 1'b0;
    #1;
    total++;
    if (rdat(0) !== 32'd0 || rdat(1) !== 32'd0 || bus.rd_busy !== 2'b00 || bus.stall !== 1'b0) begin bad++; $display("FAIL mid_reset_rd got=%h/%h/%b/%b exp=0/0/00/0", rdat(0), rdat(1), bus.rd_busy, bus.stall); end
    total++;
    if (bus.dbg_reg !== 32'd0 || bus.sb_err !== 1'b0) begin bad++; $display("FAIL mid_reset_st got=%h/%b exp=0/0", bus.dbg_reg, bus.sb_err); end
    tick;
    total++;
    if (rdat(1) !== 32'd0) begin bad++; $display("FAIL reset_drop_wb got=%h exp=0", rdat(1)); end
    idle;
    @(negedge clk) rst_n = 1'b1;
    set_rd(0, 5'd4);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    tick;
    bus.iss_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h44;
    tick;
    idle;
    #1;
    total++;
    if (rdat(0) !== 32'h44 || bus.stall !== 1'b0 || bus.sb_err !== 1'b0) begin bad++; $display("FAIL post_reset got=%h/%b/%b exp=44/0/0", rdat(0), bus.stall, bus.sb_err); end
  endtask

  initial begin
    bus.rd_addr = '0;
    bus.iss_valid = 1'b0;
    bus.iss_addr = '0;
    bus.wb_valid = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    test_reset;
    test_write_read;
    test_busy;
    test_zero;
    test_same_cycle;
    test_dbg_and_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with configurable read-port count, asynchronous active-low reset and an integrated per-register scoreboard for the pipelined core. It sits between decode (read ports, destination issue) and writeback (write port). It replaces the fixed two-read, clock-read register file. Reads are now combinational. Hazard status is reported per read port, and a registered debug tap exposes one architectural register.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NUM_RD, 2, number of read ports (1–4)
- DBG_REG, 10, index mirrored on dbg_reg

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i is at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, combinational
- rd_busy  out  NUM_RD  addressed register has a pending producer
- stall  out  1  OR of rd_busy
- iss_valid  in  1  mark iss_addr as pending
- iss_addr  in  ADDR_WIDTH  destination of the issuing instruction
- wb_valid  in  1  writeback strobe
- wb_addr  in  ADDR_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback value
- dbg_reg  out  DATA_WIDTH  registered copy of register DBG_REG
- sb_err  out  1  sticky scoreboard protocol error

## Operation
- Register 0:
  - always reads 0
  - writes to it are ignored
  - never marked busy
  - never raises sb_err
- Write: when wb_valid is high and wb_addr != 0, the array entry is updated at the edge.
- Read: rd_data[i] is the array value at rd_addr[i], purely combinational.
- Scoreboard: one busy bit per register.
  - Set at the edge when iss_valid is high and iss_addr != 0.
  - Cleared at the edge when wb_valid is high and wb_addr != 0.
  - iss and wb to the same address in the same cycle: busy ends set (the new producer wins); data is still written.
- rd_busy[i] = busy[rd_addr[i]], with the bypass exception below. rd_busy[i] = 0 when rd_addr[i] = 0.
- sb_err is set, and stays set until reset, on either of:
  - iss_valid to a register already busy that is not being cleared in the same cycle;
  - wb_valid to a non-busy register (addr != 0).
- The offending write is still performed.
- dbg_reg <= array[DBG_REG] each edge, so it shows the array contents one cycle late.

## Timing
- Reset (rst_n low, asynchronous):
  - all array entries 0
  - all busy bits 0
  - dbg_reg 0
  - sb_err 0
  - rd_data therefore reads 0 and rd_busy/stall read 0
- Write-to-read latency: 1 cycle without bypass. A write at edge N is visible on rd_data after N.
- Issue-to-busy latency: 1 cycle. rd_busy rises after the issuing edge.
- Writeback clears busy at the edge. Without bypass, the reader sees busy=0 and the new data in the same following cycle.
- dbg_reg lags an array write by 1 cycle: write at edge N, dbg_reg updates at edge N+1.
- Reset asserted mid-operation discards pending writes and busy bits immediately. The first edge after deassertion behaves as from clean reset.
- Multiple read ports may address the same register; each is resolved independently.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wb_valid is high and wb_addr == rd_addr[i] != 0, rd_data[i] = wb_data in the same cycle.
  - rd_busy[i] is forced 0 for that port, unless iss_valid targets the same address that cycle.
  - Write-to-read latency becomes 0.
- Not defined: no forwarding. rd_data comes from the array only and rd_busy reflects the stored busy bit.

## Structure
- Package reg_file_pkg holds:
  - default ADDR_WIDTH/DATA_WIDTH localparams
  - addr_t and data_t typedefs
  - REG_ZERO constant (0)
- Sub-module reg_scoreboard holds:
  - busy bit vector
  - set/clear priority
  - sb_err logic
  - per-port busy lookup
- The top level holds the array, read muxes, bypass and dbg_reg.

## Test plan
- Reset, then read all ports at addresses 0..31 -> rd_data = 0, stall = 0, dbg_reg = 0, sb_err = 0.
- wb to x5 = 0xDEADBEEF, read x5 on port 0 in the same cycle -> 0 without bypass, 0xDEADBEEF with REGFILE_BYPASS_EN. Next cycle -> 0xDEADBEEF in both builds.
- Issue x7, next cycle read x7 -> rd_busy[0] = 1, stall = 1. wb x7 = 0x12 -> busy clears and data reads 0x12.
- Simultaneous iss and wb to x3 with x3 busy -> x3 stays busy, data written, sb_err stays 0. Then wb to x9 while x9 is not busy -> sb_err = 1 until rst_n is low.
- wb to x0 = 0xFFFFFFFF and iss x0 -> x0 reads 0, never busy, sb_err stays 0.
- wb x10 = 0x55 at edge N -> dbg_reg = 0x55 after edge N+1. Assert rst_n low mid-sequence -> all outputs 0 immediately.
